// File: rtl/alu_unit.sv
// Two-stage RV32I integer/branch execution unit driving the ALU half of the CDB.
// Stage 1 captures an issued instruction, stage 2 computes and broadcasts it.
module alu_unit #(
  parameter int unsigned ENTRY_W = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               new_calculate,
  input  logic [5:0]         rs_op_out,
  input  logic [31:0]        rs_instruct_out,
  input  logic [31:0]        rs_vj_out,
  input  logic [31:0]        rs_vk_out,
  input  logic [31:0]        rs_imm_out,
  input  logic [31:0]        rs_pc_out,
  input  logic [ENTRY_W-1:0] rs_entry_out,
  output logic               alu_broadcast,
  output logic [ENTRY_W-1:0] alu_entry,
  output logic [31:0]        alu_value,
  output logic [31:0]        alu_pc_out,
  output logic               alu_jump
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [ENTRY_W-1:0] ENTRY_NULL = '0;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;

  logic               r_s1_valid;
  logic [OP_W-1:0]    r_s1_op;
  logic [DATA_W-1:0]  r_s1_vj;
  logic [DATA_W-1:0]  r_s1_vk;
  logic [DATA_W-1:0]  r_s1_imm;
  logic [DATA_W-1:0]  r_s1_pc;
  logic [ENTRY_W-1:0] r_s1_entry;

  logic [DATA_W-1:0]  w_value;
  logic [DATA_W-1:0]  w_npc;
  logic               w_jump;
  logic               w_is_br;
  logic               w_taken;
  logic [DATA_W-1:0]  w_pc4;
  logic [DATA_W-1:0]  w_br_tgt;
  logic [DATA_W-1:0]  w_jalr_sum;
  logic [SHAMT_W-1:0] w_sh_r;
  logic [SHAMT_W-1:0] w_sh_i;
  logic               w_unused_instr;

  // The raw instruction is only carried for debug visibility upstream.
  assign w_unused_instr = ^rs_instruct_out;

  // Stage 1: capture; roll_back overrides a stall.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_vj    <= '0;
      r_s1_vk    <= '0;
      r_s1_imm   <= '0;
      r_s1_pc    <= '0;
      r_s1_entry <= '0;
    end else if (roll_back) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_vj    <= '0;
      r_s1_vk    <= '0;
      r_s1_imm   <= '0;
      r_s1_pc    <= '0;
      r_s1_entry <= '0;
    end else if (rdy_in) begin
      r_s1_valid <= new_calculate && (rs_entry_out != ENTRY_NULL);
      r_s1_op    <= rs_op_out;
      r_s1_vj    <= rs_vj_out;
      r_s1_vk    <= rs_vk_out;
      r_s1_imm   <= rs_imm_out;
      r_s1_pc    <= rs_pc_out;
      r_s1_entry <= rs_entry_out;
    end
  end

  assign w_pc4      = r_s1_pc + DATA_W'(4);
  assign w_br_tgt   = r_s1_pc + r_s1_imm;
  assign w_jalr_sum = r_s1_vj + r_s1_imm;
  assign w_sh_r     = r_s1_vk[SHAMT_W-1:0];
  assign w_sh_i     = r_s1_imm[SHAMT_W-1:0];

  // Result, next PC and jump flag for the instruction held in stage 1.
  always_comb begin
    w_value = '0;
    w_npc   = w_pc4;
    w_jump  = 1'b0;
    w_is_br = 1'b0;
    w_taken = 1'b0;
    case (r_s1_op)
      OP_LUI:   w_value = r_s1_imm;
      OP_AUIPC: w_value = w_br_tgt;
      OP_JAL: begin
        w_value = w_pc4;
        w_npc   = w_br_tgt;
        w_jump  = 1'b1;
      end
      OP_JALR: begin
        w_value = w_pc4;
        w_npc   = {w_jalr_sum[DATA_W-1:1], 1'b0};
        w_jump  = 1'b1;
      end
      OP_BEQ:  begin w_is_br = 1'b1; w_taken = (r_s1_vj == r_s1_vk); end
      OP_BNE:  begin w_is_br = 1'b1; w_taken = (r_s1_vj != r_s1_vk); end
      OP_BLT:  begin w_is_br = 1'b1; w_taken = ($signed(r_s1_vj) <  $signed(r_s1_vk)); end
      OP_BGE:  begin w_is_br = 1'b1; w_taken = ($signed(r_s1_vj) >= $signed(r_s1_vk)); end
      OP_BLTU: begin w_is_br = 1'b1; w_taken = (r_s1_vj <  r_s1_vk); end
      OP_BGEU: begin w_is_br = 1'b1; w_taken = (r_s1_vj >= r_s1_vk); end
      OP_ADDI:  w_value = r_s1_vj + r_s1_imm;
      OP_SLTI:  w_value = {31'd0, $signed(r_s1_vj) < $signed(r_s1_imm)};
      OP_SLTIU: w_value = {31'd0, r_s1_vj < r_s1_imm};
      OP_XORI:  w_value = r_s1_vj ^ r_s1_imm;
      OP_ORI:   w_value = r_s1_vj | r_s1_imm;
      OP_ANDI:  w_value = r_s1_vj & r_s1_imm;
      OP_SLLI:  w_value = r_s1_vj << w_sh_i;
      OP_SRLI:  w_value = r_s1_vj >> w_sh_i;
      OP_SRAI:  w_value = $unsigned($signed(r_s1_vj) >>> w_sh_i);
      OP_ADD:   w_value = r_s1_vj + r_s1_vk;
      OP_SUB:   w_value = r_s1_vj - r_s1_vk;
      OP_SLL:   w_value = r_s1_vj << w_sh_r;
      OP_SLT:   w_value = {31'd0, $signed(r_s1_vj) < $signed(r_s1_vk)};
      OP_SLTU:  w_value = {31'd0, r_s1_vj < r_s1_vk};
      OP_XOR:   w_value = r_s1_vj ^ r_s1_vk;
      OP_SRL:   w_value = r_s1_vj >> w_sh_r;
      OP_SRA:   w_value = $unsigned($signed(r_s1_vj) >>> w_sh_r);
      OP_OR:    w_value = r_s1_vj | r_s1_vk;
      OP_AND:   w_value = r_s1_vj & r_s1_vk;
      default:  w_value = '0;
    endcase
    if (w_is_br) begin
      w_value = {31'd0, w_taken};
      w_jump  = w_taken;
      w_npc   = w_taken ? w_br_tgt : w_pc4;
    end
  end

  // Stage 2: payload only advances with a valid result so idle cycles keep it stable.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= '0;
      alu_value     <= '0;
      alu_pc_out    <= '0;
      alu_jump      <= 1'b0;
    end else if (roll_back) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= '0;
      alu_value     <= '0;
      alu_pc_out    <= '0;
      alu_jump      <= 1'b0;
    end else if (rdy_in) begin
      alu_broadcast <= r_s1_valid;
      if (r_s1_valid) begin
        alu_entry  <= r_s1_entry;
        alu_value  <= w_value;
        alu_pc_out <= w_npc;
        alu_jump   <= w_jump;
      end
    end
  end

endmodule
